// File: rtl/pipelined_rc_adder_if.sv
// Streaming operand/result bus for pipelined_rc_adder.
// The ovf_out signal exists only when PRA_OVF_EN is defined.
interface pipelined_rc_adder_if #(
  parameter int WIDTH = 16
);
  logic             valid_in;
  logic             ready_out;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub_in;
  logic             valid_out;
  logic             ready_in;
  logic [WIDTH-1:0] s;
  logic             carry_out;
`ifdef PRA_OVF_EN
  logic             ovf_out;
`endif

  // Adder side.
  modport slave (
    input  valid_in, a, b, c_in, sub_in, ready_in,
    output ready_out, valid_out, s, carry_out
`ifdef PRA_OVF_EN
    , output ovf_out
`endif
  );

  // Environment side: produces operands, consumes results.
  modport master (
    output valid_in, a, b, c_in, sub_in, ready_in,
    input  ready_out, valid_out, s, carry_out
`ifdef PRA_OVF_EN
    , input ovf_out
`endif
  );
endinterface

// File: rtl/pipelined_rc_adder.sv
// WIDTH-bit add/subtract with the carry chain cut into SEG-bit ripple segments, one register
// stage per segment, valid/ready streaming with global stall. Define PRA_OVF_EN for ovf_out.
module pipelined_rc_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipelined_rc_adder_if.slave  bus
);
  localparam int STAGES = WIDTH / SEG;

  if ((WIDTH % SEG) != 0 || WIDTH < SEG) begin : g_bad_cfg
    $error("pipelined_rc_adder: WIDTH (%0d) must be a non-zero multiple of SEG (%0d)", WIDTH, SEG);
  end

  // A full pipeline with no downstream space freezes every stage at once.
  logic w_en;
  assign w_en          = ~g_stage[STAGES-1].r_v | bus.ready_in;
  assign bus.ready_out = w_en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SEG;

    logic [WIDTH-1:LO]    w_a_in;
    logic [WIDTH-1:LO]    w_b_in;
    logic                 w_c_in;
    logic                 w_v_in;
    logic [SEG:0]         w_seg;
    logic [LO+SEG-1:0]    r_s;
    logic                 r_c;
    logic                 r_v;

    if (k == 0) begin : g_head
      // Subtraction is a + ~b + ~c_in; sub_in travels no further than this stage.
      assign w_a_in = bus.a;
      assign w_b_in = bus.sub_in ? ~bus.b : bus.b;
      assign w_c_in = bus.c_in ^ bus.sub_in;
      assign w_v_in = bus.valid_in;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s <= '0;
        end else if (w_en) begin
          r_s <= w_seg[SEG-1:0];
        end
      end
    end else begin : g_body
      assign w_a_in = g_stage[k-1].g_fwd.r_a;
      assign w_b_in = g_stage[k-1].g_fwd.r_b;
      assign w_c_in = g_stage[k-1].r_c;
      assign w_v_in = g_stage[k-1].r_v;

      // Resolved low sum bits ride along so the result leaves the last stage aligned.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s <= '0;
        end else if (w_en) begin
          r_s <= {w_seg[SEG-1:0], g_stage[k-1].r_s};
        end
      end
    end

    assign w_seg = {1'b0, w_a_in[LO +: SEG]} + {1'b0, w_b_in[LO +: SEG]} + {{SEG{1'b0}}, w_c_in};

    // NOTE: sequential state uses non-blocking assignment so every stage samples the
    // pre-edge value of its predecessor, regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_c <= 1'b0;
        r_v <= 1'b0;
      end else if (w_en) begin
        r_c <= w_seg[SEG];
        r_v <= w_v_in;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      // Operand bits not yet consumed by any segment (skew registers).
      logic [WIDTH-1:LO+SEG] r_a;
      logic [WIDTH-1:LO+SEG] r_b;

      // NOTE: datapath skew registers are reset too; it costs little here and keeps
      // post-reset state fully deterministic for equivalence and X-propagation checks.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_en) begin
          r_a <= w_a_in[WIDTH-1:LO+SEG];
          r_b <= w_b_in[WIDTH-1:LO+SEG];
        end
      end
    end
  end

  assign bus.valid_out = g_stage[STAGES-1].r_v;
  assign bus.s         = g_stage[STAGES-1].r_s;
  assign bus.carry_out = g_stage[STAGES-1].r_c;

`ifdef PRA_OVF_EN
  // Carry into the MSB is recovered from the MSB sum bit: cin = a ^ b' ^ sum.
  logic w_msb_carry_in;
  logic r_ovf;

  assign w_msb_carry_in = g_stage[STAGES-1].w_a_in[WIDTH-1]
                        ^ g_stage[STAGES-1].w_b_in[WIDTH-1]
                        ^ g_stage[STAGES-1].w_seg[SEG-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_en) begin
      r_ovf <= w_msb_carry_in ^ g_stage[STAGES-1].w_seg[SEG];
    end
  end

  assign bus.ovf_out = r_ovf;
`endif
endmodule
